// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider: per-channel square wave plus one-cycle tick per period.
// Optional macro CLK_DIV_SYNC_EN adds a `sync` input that phase-aligns every channel.
module clk_div_multi #(
  parameter int          NCH      = 4,
  parameter int          CNT_W    = 32,
  parameter int unsigned DEF_HALF = 32'd2_500_000,
  localparam int         SEL_W    = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             div_wr,
  input  logic [SEL_W-1:0] div_sel,
  input  logic [CNT_W-1:0] div_val,
`ifdef CLK_DIV_SYNC_EN
  input  logic             sync,
`endif
  output logic [NCH-1:0]   sq,
  output logic [NCH-1:0]   tick
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] half_r [NCH];
  logic [CNT_W-1:0] half_s [NCH];
  logic [CNT_W-1:0] cnt_r  [NCH];
  logic [CNT_W-1:0] cnt_s  [NCH];
  logic [NCH-1:0]   sq_r;
  logic [NCH-1:0]   sq_s;
  logic [NCH-1:0]   tick_r;
  logic [NCH-1:0]   tick_s;
  logic             sync_s;

`ifdef CLK_DIV_SYNC_EN
  assign sync_s = sync;
`else
  assign sync_s = 1'b0;
`endif

  // Next-state per channel; a write beats sync, which beats disable and counting.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      half_s[i] = half_r[i];
      cnt_s[i]  = cnt_r[i];
      sq_s[i]   = sq_r[i];
      tick_s[i] = 1'b0;
      if (div_wr && (int'(div_sel) == i)) begin
        half_s[i] = div_val;
        cnt_s[i]  = CNT_ZERO;
        sq_s[i]   = 1'b0;
      end else if (sync_s) begin
        cnt_s[i]  = CNT_ZERO;
        sq_s[i]   = 1'b0;
      end else if (half_r[i] == CNT_ZERO) begin
        cnt_s[i]  = CNT_ZERO;
        sq_s[i]   = 1'b0;
      end else if (en) begin
        if (cnt_r[i] == (half_r[i] - CNT_ONE)) begin
          cnt_s[i]  = CNT_ZERO;
          sq_s[i]   = ~sq_r[i];
          tick_s[i] = ~sq_r[i];
        end else begin
          cnt_s[i]  = cnt_r[i] + CNT_ONE;
          sq_s[i]   = sq_r[i];
          tick_s[i] = 1'b0;
        end
      end else begin
        cnt_s[i]  = cnt_r[i];
        sq_s[i]   = sq_r[i];
      end
    end
  end

  // State and output registers with synchronous reset to the default half-period.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        half_r[i] <= CNT_W'(DEF_HALF);
        cnt_r[i]  <= CNT_ZERO;
      end
      sq_r   <= {NCH{1'b0}};
      tick_r <= {NCH{1'b0}};
    end else begin
      for (int i = 0; i < NCH; i++) begin
        half_r[i] <= half_s[i];
        cnt_r[i]  <= cnt_s[i];
      end
      sq_r   <= sq_s;
      tick_r <= tick_s;
    end
  end

  assign sq   = sq_r;
  assign tick = tick_r;

endmodule

// File: tb/tb_clk_div_multi.sv
// Self-checking bench for clk_div_multi: two instances (NCH=4 and NCH=6) against a phase-count model.
module tb_clk_div_multi;

  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst, en, sync;
  logic          div_wr_a, div_wr_b;
  logic [1:0]    div_sel_a;
  logic [2:0]    div_sel_b;
  logic [CW-1:0] div_val;
  logic [3:0]    sq_a, tick_a;
  logic [5:0]    sq_b, tick_b;

  always #5 clk = ~clk;

  clk_div_multi #(.NCH(4), .CNT_W(CW), .DEF_HALF(5)) u_dut_a (
    .clk(clk), .rst(rst), .en(en), .div_wr(div_wr_a), .div_sel(div_sel_a), .div_val(div_val),
`ifdef CLK_DIV_SYNC_EN
    .sync(sync),
`endif
    .sq(sq_a), .tick(tick_a)
  );

  clk_div_multi #(.NCH(6), .CNT_W(CW), .DEF_HALF(3)) u_dut_b (
    .clk(clk), .rst(rst), .en(en), .div_wr(div_wr_b), .div_sel(div_sel_b), .div_val(div_val),
`ifdef CLK_DIV_SYNC_EN
    .sync(sync),
`endif
    .sq(sq_b), .tick(tick_b)
  );

  int checks = 0;
  int failures = 0;

  // Model: channels 0..3 belong to DUT A, 4..9 to DUT B.
  // mp counts enabled edges since the last restart; sq and tick follow by arithmetic.
  int     mh [10];
  longint mp [10];
  bit     mt [10];
  int     cnt_a [4];
  int     cnt_b [6];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit exp_sq(input int i);
    if (mh[i] == 0) return 1'b0;
    return ((mp[i] / mh[i]) % 2) == 1;
  endfunction

  task automatic model_edge();
    bit wr;
    for (int i = 0; i < 10; i++) begin
      mt[i] = 1'b0;
      if (rst) begin
        mh[i] = (i < 4) ? 5 : 3;
        mp[i] = 0;
      end else begin
        wr = (i < 4) ? (div_wr_a && int'(div_sel_a) == i) : (div_wr_b && int'(div_sel_b) == i - 4);
        if (wr) begin
          mh[i] = int'(div_val);
          mp[i] = 0;
        end else if (sync || mh[i] == 0) begin
          mp[i] = 0;
        end else if (en) begin
          mp[i]++;
          mt[i] = (mp[i] % (2 * mh[i])) == mh[i];
        end
      end
    end
  endtask

  task automatic compare_all();
    logic [3:0] esq_a, etk_a;
    logic [5:0] esq_b, etk_b;
    for (int i = 0; i < 4; i++) begin esq_a[i] = exp_sq(i); etk_a[i] = mt[i]; end
    for (int i = 0; i < 6; i++) begin esq_b[i] = exp_sq(i + 4); etk_b[i] = mt[i + 4]; end
    chk("sq_a", int'(sq_a), int'(esq_a));
    chk("tick_a", int'(tick_a), int'(etk_a));
    chk("sq_b", int'(sq_b), int'(esq_b));
    chk("tick_b", int'(tick_b), int'(etk_b));
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
    for (int i = 0; i < 4; i++) cnt_a[i] += int'(tick_a[i]);
    for (int i = 0; i < 6; i++) cnt_b[i] += int'(tick_b[i]);
  endtask

  task automatic run_count(input int ncyc);
    for (int i = 0; i < 4; i++) cnt_a[i] = 0;
    for (int i = 0; i < 6; i++) cnt_b[i] = 0;
    repeat (ncyc) cyc();
  endtask

  task automatic wait_tick(input int ch, input int budget, output int n);
    n = 0;
    while (n < budget) begin
      cyc();
      n++;
      if (tick_a[ch]) return;
    end
    n = -1;
  endtask

  task automatic write_a(input int ch, input int val);
    div_wr_a  = 1'b1;
    div_sel_a = 2'(ch);
    div_val   = CW'(val);
    cyc();
    div_wr_a  = 1'b0;
  endtask

  typedef struct {
    logic [3:0][15:0] h;
    int               win;
    logic [3:0][7:0]  exp_t;
  } vec_t;

  vec_t tbl [4];
  int   n, first0, first1;

  initial begin
    tbl[0] = '{h: {16'd7, 16'd3, 16'd2, 16'd1}, win: 84,  exp_t: {8'd6,  8'd14, 8'd21, 8'd42}};
    tbl[1] = '{h: {16'd5, 16'd5, 16'd5, 16'd5}, win: 100, exp_t: {8'd10, 8'd10, 8'd10, 8'd10}};
    tbl[2] = '{h: {16'd6, 16'd0, 16'd1, 16'd4}, win: 48,  exp_t: {8'd4,  8'd0,  8'd24, 8'd6}};
    tbl[3] = '{h: {16'd9, 16'd4, 16'd3, 16'd2}, win: 72,  exp_t: {8'd4,  8'd9,  8'd12, 8'd18}};

    rst = 1'b1; en = 1'b1; sync = 1'b0;
    div_wr_a = 1'b0; div_wr_b = 1'b0; div_sel_a = 2'd0; div_sel_b = 3'd0; div_val = '0;
    for (int i = 0; i < 10; i++) begin mh[i] = 0; mp[i] = 0; mt[i] = 1'b0; end

    // Reset defaults: first rise on the 5th edge, all in phase, period 10.
    cyc(); cyc();
    rst = 1'b0;
    wait_tick(0, 20, n);
    chk("rst_first_tick", n, 5);
    chk("rst_in_phase", int'(sq_a), 15);
    wait_tick(0, 30, n);
    chk("rst_tick_period", n, 10);

    // Out-of-range writes on the 6-channel instance leave every H at 3.
    div_wr_b = 1'b1; div_sel_b = 3'd6; div_val = 16'd1; cyc();
    div_sel_b = 3'd7; div_val = 16'd0; cyc();
    div_wr_b = 1'b0;
    run_count(12);
    for (int i = 0; i < 6; i++) chk("oor_ticks_b", cnt_b[i], 2);

    // Table: program all four channels with counting paused, then count ticks.
    for (int t = 0; t < 4; t++) begin
      en = 1'b0;
      for (int ch = 0; ch < 4; ch++) write_a(ch, int'(tbl[t].h[ch]));
      en = 1'b1;
      run_count(tbl[t].win);
      for (int ch = 0; ch < 4; ch++) chk("tbl_ticks", cnt_a[ch], int'(tbl[t].exp_t[ch]));
    end

    // Enable gating: H=4, two edges counted, three edges paused -> tick 3 late.
    write_a(0, 4);
    cyc(); cyc();
    en = 1'b0;
    run_count(3);
    chk("gate_no_tick", cnt_a[0], 0);
    en = 1'b1;
    wait_tick(0, 20, n);
    chk("gate_late_tick", n, 2);

    // Mid-count rewrite with sq high.
    write_a(1, 8);
    repeat (10) cyc();
    chk("rewrite_sq_before", int'(sq_a[1]), 1);
    write_a(1, 3);
    chk("rewrite_sq_cleared", int'(sq_a[1]), 0);
    wait_tick(1, 20, n);
    chk("rewrite_first_tick", n, 3);

`ifdef CLK_DIV_SYNC_EN
    // Sync realigns channels at H=3 and H=5.
    write_a(0, 3);
    write_a(1, 5);
    repeat (7) cyc();
    sync = 1'b1; cyc(); sync = 1'b0;
    chk("sync_sq_cleared", int'(sq_a[1:0]), 0);
    first0 = -1; first1 = -1;
    for (int k = 1; k <= 8; k++) begin
      cyc();
      if (sq_a[0] && first0 < 0) first0 = k;
      if (sq_a[1] && first1 < 0) first1 = k;
    end
    chk("sync_rise_h3", first0, 3);
    chk("sync_rise_h5", first1, 5);
`endif

    // Reset mid-count restores the default half-period everywhere.
    write_a(2, 7);
    repeat (4) cyc();
    rst = 1'b1; cyc(); rst = 1'b0;
    wait_tick(0, 20, n);
    chk("rst_mid_first_tick", n, 5);
    chk("rst_mid_in_phase", int'(sq_a), 15);

    // Randomized traffic against the model.
    for (int k = 0; k < 1500; k++) begin
      en        = ($urandom_range(0, 9) != 0);
      div_wr_a  = ($urandom_range(0, 15) == 0);
      div_sel_a = 2'($urandom_range(0, 3));
      div_wr_b  = ($urandom_range(0, 15) == 0);
      div_sel_b = 3'($urandom_range(0, 7));
      div_val   = CW'($urandom_range(0, 9));
`ifdef CLK_DIV_SYNC_EN
      sync      = ($urandom_range(0, 39) == 0);
`endif
      rst       = ($urandom_range(0, 199) == 0);
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
